// File: rtl/calc_cmd_sequencer.sv
// Keypad command FIFO and single-outstanding issue controller for the calculator core.
// Each command is held until the core goes busy and then returns to ready; stalls and core faults are flagged.
module calc_cmd_sequencer #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CW      = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     key_valid,
  input  logic [CW-1:0]            key_code,
  output logic                     key_ready,
  input  logic [1:0]               calc_status,
  output logic [CW-1:0]            cmd_out,
  output logic                     cmd_valid,
  input  logic                     clear_err,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     timeout,
  output logic                     error
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;
  localparam logic [1:0]  STATUS_ERROR = 2'b00;
  localparam logic [1:0]  STATUS_READY = 2'b10;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_READY, FAULT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   mem_q [DEPTH];
  logic [CW-1:0]   mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [CW-1:0]   cmd_out_q, cmd_out_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic            overflow_q, overflow_d;
  logic            timeout_q, timeout_d;
  logic            error_q, error_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            push, pop, flush;

  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    cmd_out_d   = cmd_out_q;
    cmd_valid_d = cmd_valid_q;
    overflow_d  = overflow_q;
    timeout_d   = timeout_q;
    timer_d     = timer_q;
    pop         = 1'b0;
    flush       = 1'b0;

    key_ready = (count_q != (AW+1)'(DEPTH)) && (state_q != FAULT);
    busy      = !((state_q == IDLE) && (count_q == '0));
    push      = key_valid && key_ready;

    // A fresh overflow in the same cycle as clear_err still sticks.
    if (clear_err) begin
      overflow_d = 1'b0;
      timeout_d  = 1'b0;
    end
    if (key_valid && !key_ready) overflow_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (calc_status == STATUS_ERROR) begin
          state_d = FAULT;
          flush   = 1'b1;
        end else if ((count_q != '0) && (calc_status == STATUS_READY)) begin
          pop         = 1'b1;
          cmd_out_d   = mem_q[rd_ptr_q];
          cmd_valid_d = 1'b1;
          timer_d     = '0;
          state_d     = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (calc_status == STATUS_ERROR) begin
          cmd_valid_d = 1'b0;
          state_d     = FAULT;
          flush       = 1'b1;
        end else if (calc_status[0]) begin
          cmd_valid_d = 1'b0;
          state_d     = WAIT_READY;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          cmd_valid_d = 1'b0;
          timeout_d   = 1'b1;
          state_d     = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT_READY: begin
        if (calc_status == STATUS_READY) begin
          state_d = IDLE;
        end else if (calc_status == STATUS_ERROR) begin
          state_d = FAULT;
          flush   = 1'b1;
        end
      end
      FAULT: begin
        cmd_valid_d = 1'b0;
        if (clear_err) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = key_code;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push) count_d = count_q - (AW+1)'(1);

    // Flush on fault entry wins over any push accepted in the same cycle.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    error_d = (state_d == FAULT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_out_q   <= '0;
      cmd_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      timeout_q   <= 1'b0;
      error_q     <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cmd_out_q   <= cmd_out_d;
      cmd_valid_q <= cmd_valid_d;
      overflow_q  <= overflow_d;
      timeout_q   <= timeout_d;
      error_q     <= error_d;
      timer_q     <= timer_d;
    end
  end

  assign cmd_out    = cmd_out_q;
  assign cmd_valid  = cmd_valid_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign timeout    = timeout_q;
  assign error      = error_q;

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Bench for calc_cmd_sequencer: directed scenarios plus randomized traffic against a queue-based model.
module tb_calc_cmd_sequencer;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned CW      = 4;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic                   key_valid = 1'b0;
  logic [CW-1:0]          key_code = '0;
  logic [1:0]             calc_status = 2'b01;
  logic                   clear_err = 1'b0;
  logic                   key_ready, cmd_valid, busy, overflow, timeout, error;
  logic [CW-1:0]          cmd_out;
  logic [$clog2(DEPTH):0] fifo_count;

  int checks = 0;
  int errors = 0;

  // Reference model: pending queue plus flags for "command outstanding",
  // "core accepted, waiting to be ready again" and "faulted".
  logic [CW-1:0] mq[$];
  bit            m_fault, m_pending, m_acked, m_ovf, m_to, m_cv;
  logic [CW-1:0] m_cmd;
  int            m_wait;

  calc_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clock(clock), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .calc_status(calc_status), .cmd_out(cmd_out),
    .cmd_valid(cmd_valid), .clear_err(clear_err), .busy(busy),
    .fifo_count(fifo_count), .overflow(overflow), .timeout(timeout), .error(error)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    mq.delete();
    m_fault = 0; m_pending = 0; m_acked = 0; m_ovf = 0; m_to = 0; m_cv = 0;
    m_cmd = '0; m_wait = 0;
  endtask

  task automatic model_edge(input bit kv, input logic [CW-1:0] kc, input logic [1:0] st, input bit ce);
    bit can_take;
    bit do_push;
    can_take = (mq.size() < DEPTH) && !m_fault;
    do_push  = kv && can_take;
    if (ce) begin m_ovf = 0; m_to = 0; end
    if (kv && !can_take) m_ovf = 1;
    if (m_fault) begin
      if (ce) m_fault = 0;
    end else if (st == 2'b00) begin
      m_fault = 1; m_cv = 0; m_pending = 0; m_acked = 0;
      mq.delete(); do_push = 0;
    end else if (m_pending) begin
      if (st == 2'b01 || st == 2'b11) begin
        m_pending = 0; m_acked = 1; m_cv = 0;
      end else if (m_wait == TIMEOUT - 1) begin
        m_pending = 0; m_cv = 0; m_to = 1;
      end else begin
        m_wait++;
      end
    end else if (m_acked) begin
      if (st == 2'b10) m_acked = 0;
    end else if (mq.size() > 0 && st == 2'b10) begin
      m_cmd = mq.pop_front(); m_cv = 1; m_pending = 1; m_wait = 0;
    end
    if (do_push) mq.push_back(kc);
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge(key_valid, key_code, calc_status, clear_err);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    model_reset();
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid: got %0b want 0", cmd_valid); end
    checks++; if (cmd_out !== 4'd0) begin errors++; $display("FAIL reset_cmd_out: got %0d want 0", cmd_out); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    checks++; if ({overflow, timeout, error} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {overflow, timeout, error}); end
    checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL reset_key_ready: got %0b want 1", key_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_basic_issue();
    calc_status = 2'b01; key_valid = 1'b1; key_code = 4'd3; tick();
    key_code = 4'd5; tick();
    key_valid = 1'b0;
    checks++; if (fifo_count !== 4'd2) begin errors++; $display("FAIL basic_count2: got %0d want 2", fifo_count); end
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL basic_no_issue_busy: got %0b want 0", cmd_valid); end
    calc_status = 2'b10; tick();
    checks++; if (cmd_valid !== 1'b1 || cmd_out !== 4'd3) begin errors++; $display("FAIL basic_issue3: got v=%0b c=%0d want v=1 c=3", cmd_valid, cmd_out); end
    checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL basic_count1: got %0d want 1", fifo_count); end
    calc_status = 2'b01; tick();
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL basic_ack_drop: got %0b want 0", cmd_valid); end
    repeat (3) tick();
    checks++; if (cmd_out !== 4'd3 || busy !== 1'b1) begin errors++; $display("FAIL basic_hold: got c=%0d busy=%0b want c=3 busy=1", cmd_out, busy); end
    calc_status = 2'b10; tick();
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL basic_gap: got %0b want 0", cmd_valid); end
    tick();
    checks++; if (cmd_valid !== 1'b1 || cmd_out !== 4'd5 || fifo_count !== 4'd0) begin
      errors++; $display("FAIL basic_issue5: got v=%0b c=%0d n=%0d want v=1 c=5 n=0", cmd_valid, cmd_out, fifo_count); end
    calc_status = 2'b01; tick();
    calc_status = 2'b10; tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %0b want 0", busy); end
  endtask

  task automatic test_full();
    calc_status = 2'b01;
    for (int i = 0; i < 9; i++) begin
      checks++; if (key_ready !== (i < 8)) begin errors++; $display("FAIL full_ready_%0d: got %0b want %0b", i, key_ready, (i < 8)); end
      key_valid = 1'b1; key_code = CW'(i); tick();
    end
    key_valid = 1'b0;
    checks++; if (fifo_count !== 4'd8 || overflow !== 1'b1 || key_ready !== 1'b0) begin
      errors++; $display("FAIL full_state: got n=%0d ovf=%0b rdy=%0b want n=8 ovf=1 rdy=0", fifo_count, overflow, key_ready); end
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    checks++; if (overflow !== 1'b0 || fifo_count !== 4'd8) begin
      errors++; $display("FAIL full_clear: got ovf=%0b n=%0d want ovf=0 n=8", overflow, fifo_count); end
    calc_status = 2'b00; tick();
    clear_err = 1'b1; calc_status = 2'b01; tick(); clear_err = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    calc_status = 2'b01; key_valid = 1'b1; key_code = 4'd7; tick();
    key_code = 4'd8; tick(); key_valid = 1'b0;
    calc_status = 2'b10; tick();
    n = (cmd_valid === 1'b1) ? 1 : 0;
    while (cmd_valid === 1'b1 && n < 200) begin
      tick();
      if (cmd_valid === 1'b1) n++;
    end
    checks++; if (n != 64) begin errors++; $display("FAIL timeout_len: got %0d cycles want 64", n); end
    checks++; if (timeout !== 1'b1 || cmd_out !== 4'd7) begin errors++; $display("FAIL timeout_flag: got to=%0b c=%0d want to=1 c=7", timeout, cmd_out); end
    tick();
    checks++; if (cmd_valid !== 1'b1 || cmd_out !== 4'd8 || fifo_count !== 4'd0) begin
      errors++; $display("FAIL timeout_reissue: got v=%0b c=%0d n=%0d want v=1 c=8 n=0", cmd_valid, cmd_out, fifo_count); end
    calc_status = 2'b01; tick();
    calc_status = 2'b10; tick();
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %0b want 0", timeout); end
  endtask

  task automatic test_fault();
    calc_status = 2'b01; key_valid = 1'b1; key_code = 4'd1; tick();
    key_code = 4'd2; tick(); key_valid = 1'b0;
    calc_status = 2'b10; tick();
    checks++; if (cmd_valid !== 1'b1 || cmd_out !== 4'd1) begin errors++; $display("FAIL fault_issue: got v=%0b c=%0d want v=1 c=1", cmd_valid, cmd_out); end
    calc_status = 2'b00; tick();
    checks++; if (error !== 1'b1 || fifo_count !== 4'd0 || key_ready !== 1'b0 || cmd_valid !== 1'b0) begin
      errors++; $display("FAIL fault_enter: got err=%0b n=%0d rdy=%0b v=%0b want 1 0 0 0", error, fifo_count, key_ready, cmd_valid); end
    key_valid = 1'b1; key_code = 4'd9; tick(); key_valid = 1'b0;
    checks++; if (overflow !== 1'b1 || fifo_count !== 4'd0) begin
      errors++; $display("FAIL fault_push_blocked: got ovf=%0b n=%0d want ovf=1 n=0", overflow, fifo_count); end
    calc_status = 2'b10; clear_err = 1'b1; tick(); clear_err = 1'b0;
    checks++; if (error !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0 || key_ready !== 1'b1) begin
      errors++; $display("FAIL fault_clear: got err=%0b ovf=%0b busy=%0b rdy=%0b want 0 0 0 1", error, overflow, busy, key_ready); end
  endtask

  task automatic test_simultaneous();
    calc_status = 2'b01; key_valid = 1'b1; key_code = 4'd4; tick();
    calc_status = 2'b10; key_code = 4'd14; tick(); key_valid = 1'b0;
    checks++; if (fifo_count !== 4'd1 || cmd_out !== 4'd4 || cmd_valid !== 1'b1) begin
      errors++; $display("FAIL simul_pushpop: got n=%0d c=%0d v=%0b want n=1 c=4 v=1", fifo_count, cmd_out, cmd_valid); end
    calc_status = 2'b01; tick();
    calc_status = 2'b10; tick(); tick();
    checks++; if (cmd_out !== 4'd14 || cmd_valid !== 1'b1) begin errors++; $display("FAIL simul_head: got c=%0d v=%0b want c=14 v=1", cmd_out, cmd_valid); end
    calc_status = 2'b01; tick();
    calc_status = 2'b10; tick();
  endtask

  task automatic test_random();
    bit exp_busy;
    for (int i = 0; i < 600; i++) begin
      int unsigned r;
      r = $urandom_range(0, 15);
      calc_status = (r == 0) ? 2'b00 : (r < 6) ? 2'b01 : (r == 6) ? 2'b11 : 2'b10;
      key_valid   = ($urandom_range(0, 1) == 1);
      key_code    = CW'($urandom);
      clear_err   = ($urandom_range(0, 15) == 0);
      tick();
      exp_busy = m_fault || m_pending || m_acked || (mq.size() != 0);
      checks++; if (cmd_valid !== m_cv) begin errors++; $display("FAIL rand_valid @%0d: got %0b want %0b", i, cmd_valid, m_cv); end
      checks++; if (cmd_out !== m_cmd) begin errors++; $display("FAIL rand_cmd @%0d: got %0d want %0d", i, cmd_out, m_cmd); end
      checks++; if (fifo_count !== 4'(mq.size())) begin errors++; $display("FAIL rand_count @%0d: got %0d want %0d", i, fifo_count, mq.size()); end
      checks++; if (key_ready !== ((mq.size() < DEPTH) && !m_fault)) begin errors++; $display("FAIL rand_ready @%0d: got %0b", i, key_ready); end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rand_busy @%0d: got %0b want %0b", i, busy, exp_busy); end
      checks++; if ({overflow, timeout, error} !== {m_ovf, m_to, m_fault}) begin
        errors++; $display("FAIL rand_flags @%0d: got %b want %b", i, {overflow, timeout, error}, {m_ovf, m_to, m_fault}); end
    end
    key_valid = 1'b0; clear_err = 1'b0;
  endtask

  task automatic test_reset_mid();
    reset = 1'b1; #7; @(negedge clock); reset = 1'b0; model_reset();
    calc_status = 2'b01; key_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin key_code = CW'(i + 10); tick(); end
    key_valid = 1'b0;
    calc_status = 2'b10; tick();
    calc_status = 2'b01; tick();
    checks++; if (fifo_count !== 4'd4 || busy !== 1'b1) begin errors++; $display("FAIL rmid_setup: got n=%0d busy=%0b want n=4 busy=1", fifo_count, busy); end
    #2; reset = 1'b1; #1;
    model_reset();
    checks++; if (fifo_count !== 4'd0 || cmd_out !== 4'd0 || cmd_valid !== 1'b0 || busy !== 1'b0 || key_ready !== 1'b1) begin
      errors++; $display("FAIL rmid_async: got n=%0d c=%0d v=%0b busy=%0b rdy=%0b want 0 0 0 0 1", fifo_count, cmd_out, cmd_valid, busy, key_ready); end
    @(posedge clock); #1; reset = 1'b0;
    calc_status = 2'b10;
    repeat (5) tick();
    checks++; if (cmd_valid !== 1'b0 || fifo_count !== 4'd0) begin errors++; $display("FAIL rmid_no_issue: got v=%0b n=%0d want 0 0", cmd_valid, fifo_count); end
    key_valid = 1'b1; key_code = 4'd6; tick(); key_valid = 1'b0; tick();
    checks++; if (cmd_valid !== 1'b1 || cmd_out !== 4'd6) begin errors++; $display("FAIL rmid_new_issue: got v=%0b c=%0d want 1 6", cmd_valid, cmd_out); end
  endtask

  initial begin
    test_reset();
    test_basic_issue();
    test_full();
    test_timeout();
    test_fault();
    test_simultaneous();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
